// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: size encodings, queued-entry layout, pointer sizing.
// Optional load forwarding is enabled by defining STORE_BUFFER_LD_FWD_EN.
package store_buffer_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int SB_AW = 32;

  typedef struct packed {
    logic [SB_AW-3:0] addr_w;
    logic [31:0]      data;
    logic [3:0]       be;
  } entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stb_lane_align.sv
// Store lane encoder: size/offset -> byte enables, lane-replicated data, misalign flag.
// Latency: purely combinational.
// Backpressure: none; the caller gates the push with the misalign flag.
module stb_lane_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data_in,
  output logic [3:0]  be,
  output logic [31:0] data_out,
  output logic        misalign
);

  always_comb begin
    be       = 4'b0000;
    data_out = 32'h0;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        be       = 4'b0001 << addr_lo;
        data_out = {4{data_in[7:0]}};
      end
      SZ_HALF: begin
        misalign = addr_lo[0];
        be       = 4'b0011 << {addr_lo[1], 1'b0};
        data_out = {2{data_in[15:0]}};
      end
      SZ_WORD: begin
        misalign = |addr_lo;
        be       = 4'hF;
        data_out = data_in;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer with word-granular load conflict detection (forwarding under STORE_BUFFER_LD_FWD_EN).
// Latency: a pushed store reaches mem_req_o the next cycle at the earliest; pop on req & gnt.
// Backpressure: st_ready_o low while full (no same-cycle bypass); head held until granted.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     st_en_i,
  input  logic [AW-1:0]            st_addr_i,
  input  logic [31:0]              st_data_i,
  input  logic [1:0]               st_size_i,
  output logic                     st_ready_o,
  output logic                     st_misalign_o,
  input  logic                     ld_en_i,
  input  logic [AW-1:0]            ld_addr_i,
  output logic                     ld_stall_o,
  output logic                     ld_hit_o,
  output logic [31:0]              ld_data_o,
  output logic                     mem_req_o,
  output logic [AW-1:0]            mem_addr_o,
  output logic [31:0]              mem_data_o,
  output logic [3:0]               mem_be_o,
  input  logic                     mem_gnt_i,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (AW != SB_AW) begin : g_bad_aw
    $error("store_buffer: AW must equal store_buffer_pkg::SB_AW");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("store_buffer: DEPTH must be a power of two >= 2");
  end

  entry_t           mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             mis_q;

  logic [3:0]       push_be;
  logic [31:0]      push_data;
  logic             push_mis;
  logic             push, pop;
  entry_t           head;
  logic [DEPTH-1:0] match;

  stb_lane_align u_align (
    .size     (st_size_i),
    .addr_lo  (st_addr_i[1:0]),
    .data_in  (st_data_i),
    .be       (push_be),
    .data_out (push_data),
    .misalign (push_mis)
  );

  assign st_ready_o    = (count_q != FULL_CNT);
  assign empty_o       = (count_q == '0);
  assign count_o       = count_q;
  assign st_misalign_o = mis_q;
  assign push          = st_en_i & st_ready_o & ~push_mis;
  assign pop           = mem_req_o & mem_gnt_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{addr_w: st_addr_i[AW-1:2], data: push_data, be: push_be};
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      mis_q <= st_en_i & push_mis;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign mem_req_o  = ~empty_o;
  assign mem_addr_o = mem_req_o ? {head.addr_w[AW-3:0], 2'b00} : '0;
  assign mem_data_o = mem_req_o ? head.data : '0;
  assign mem_be_o   = mem_req_o ? head.be : '0;

  // Conflict is word-granular, so the byte offset of the load never matters.
  logic ld_addr_lo_unused;
  assign ld_addr_lo_unused = ^ld_addr_i[1:0];

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = vld_q[i] && (mem_q[i].addr_w[AW-3:0] == ld_addr_i[AW-1:2]);
  end

`ifdef STORE_BUFFER_LD_FWD_EN
  logic          fwd_found, fwd_full;
  logic [PW-1:0] fwd_idx, scan_idx;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr_q + PW'(k);
      if (match[scan_idx]) begin
        fwd_found = 1'b1;
        fwd_idx   = scan_idx;
      end
    end
  end

  assign fwd_full   = fwd_found && (mem_q[fwd_idx].be == 4'hF);
  assign ld_hit_o   = ld_en_i & fwd_full;
  assign ld_data_o  = (ld_en_i & fwd_full) ? mem_q[fwd_idx].data : 32'h0;
  assign ld_stall_o = ld_en_i & fwd_found & ~fwd_full;
`else
  assign ld_hit_o   = 1'b0;
  assign ld_data_o  = 32'h0;
  assign ld_stall_o = ld_en_i & (|match);
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer; bus writes are checked against a queue of expected transactions.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_en;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        st_ready, st_misalign;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic        ld_stall, ld_hit;
  logic [31:0] ld_data;
  logic        mem_req;
  logic [31:0] mem_addr, mem_data;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        empty;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .st_en_i       (st_en),
    .st_addr_i     (st_addr),
    .st_data_i     (st_data),
    .st_size_i     (st_size),
    .st_ready_o    (st_ready),
    .st_misalign_o (st_misalign),
    .ld_en_i       (ld_en),
    .ld_addr_i     (ld_addr),
    .ld_stall_o    (ld_stall),
    .ld_hit_o      (ld_hit),
    .ld_data_o     (ld_data),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_data),
    .mem_be_o      (mem_be),
    .mem_gnt_i     (mem_gnt),
    .empty_o       (empty),
    .count_o       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.be   = b;
    exp_q.push_back(e);
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    st_en   = 1'b1;
    st_addr = a;
    st_data = d;
    st_size = sz;
  endtask

  task automatic wait_empty(input string tag);
    for (int k = 0; k < 20 && !empty; k++) tick();
    chk(tag, 32'(empty), 32'd1);
  endtask

  // Bus monitor: every granted request must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_gnt) begin
      chk("bus_expected_pending", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("bus_addr", mem_addr, e.addr);
        chk("bus_data", mem_data, e.data);
        chk("bus_be", 32'(mem_be), 32'(e.be));
      end
    end
  end

  initial begin
    rst_n = 1'b0; st_en = 1'b0; st_addr = '0; st_data = '0; st_size = 2'd0;
    ld_en = 1'b0; ld_addr = '0; mem_gnt = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_misalign", 32'(st_misalign), 32'd0);
    chk("rst_stall", 32'(ld_stall), 32'd0);
    chk("rst_hit", 32'(ld_hit), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // Byte store, bus always granting.
    mem_gnt = 1'b1;
    drive_st(32'h1003, 32'h0000_00AB, 2'd0);
    push_exp(32'h1000, 32'hABAB_ABAB, 4'b1000);
    #1 chk("sb_no_same_cycle_req", 32'(mem_req), 32'd0);
    tick();
    st_en = 1'b0;
    chk("sb_req_next", 32'(mem_req), 32'd1);
    chk("sb_count1", 32'(count), 32'd1);
    tick();
    chk("sb_empty_after_gnt", 32'(empty), 32'd1);
    tick();
    chk("gnt_idle_ignored", 32'(count), 32'd0);

    // Fill to DEPTH with the bus stalled; the fifth store must be refused.
    mem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_st(32'h4000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 2'd2);
      #1 chk("fill_ready", 32'(st_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) begin
        push_exp(32'h4000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'hF);
        tick();
      end
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_head_addr", mem_addr, 32'h4000);

    // Pop while full: still not ready this cycle, accepted on the next.
    mem_gnt = 1'b1;
    #1 chk("full_pop_no_bypass", 32'(st_ready), 32'd0);
    tick();
    chk("after_pop_count", 32'(count), 32'd3);
    chk("after_pop_ready", 32'(st_ready), 32'd1);
    push_exp(32'h4010, 32'h1111_0004, 4'hF);
    tick();
    chk("push_pop_count", 32'(count), 32'd3);
    st_en = 1'b0;
    wait_empty("wrap_drain_empty");

    // Misaligned and reserved-size stores.
    mem_gnt = 1'b0;
    drive_st(32'h2001, 32'h1234, 2'd1);
    tick();
    st_en = 1'b0;
    chk("sh_misalign_pulse", 32'(st_misalign), 32'd1);
    chk("sh_misalign_count", 32'(count), 32'd0);
    tick();
    chk("sh_misalign_one_cycle", 32'(st_misalign), 32'd0);
    drive_st(32'h2000, 32'h1234, 2'd3);
    tick();
    st_en = 1'b0;
    chk("size3_misalign", 32'(st_misalign), 32'd1);
    chk("size3_count", 32'(count), 32'd0);

    // Load conflict against a pending full word.
    drive_st(32'h3000, 32'hDEAD_BEEF, 2'd2);
    push_exp(32'h3000, 32'hDEAD_BEEF, 4'hF);
    tick();
    st_en = 1'b0;
    chk("sw_count", 32'(count), 32'd1);
    ld_en = 1'b1; ld_addr = 32'h3000;
    #1;
`ifdef STORE_BUFFER_LD_FWD_EN
    chk("lw_fwd_stall", 32'(ld_stall), 32'd0);
    chk("lw_fwd_hit", 32'(ld_hit), 32'd1);
    chk("lw_fwd_data", ld_data, 32'hDEAD_BEEF);
`else
    chk("lw_stall", 32'(ld_stall), 32'd1);
    chk("lw_hit", 32'(ld_hit), 32'd0);
    chk("lw_data", ld_data, 32'd0);
`endif
    ld_addr = 32'h3004;
    #1 chk("lw_other_word", 32'(ld_stall | ld_hit), 32'd0);
    ld_en = 1'b0; ld_addr = 32'h3000;
    #1 chk("ld_disabled", 32'(ld_stall | ld_hit), 32'd0);

    // Younger partial store to the same word forces a stall in both builds.
    drive_st(32'h3001, 32'h0000_0077, 2'd0);
    push_exp(32'h3000, 32'h7777_7777, 4'b0010);
    tick();
    ld_en = 1'b1; ld_addr = 32'h3002;
    drive_st(32'h6000, 32'h600D_600D, 2'd2);
    push_exp(32'h6000, 32'h600D_600D, 4'hF);
    #1 chk("partial_stall", 32'(ld_stall), 32'd1);
    chk("partial_no_hit", 32'(ld_hit), 32'd0);
    ld_addr = 32'h6000;
    #1 chk("same_cycle_push_ignored", 32'(ld_stall | ld_hit), 32'd0);
    tick();
    st_en = 1'b0;
    #1;
`ifdef STORE_BUFFER_LD_FWD_EN
    chk("next_cycle_fwd", ld_data, 32'h600D_600D);
`else
    chk("next_cycle_stall", 32'(ld_stall), 32'd1);
`endif

    // An entry being granted this cycle still conflicts.
    ld_addr = 32'h3000;
    mem_gnt = 1'b1;
    #1 chk("popping_entry_compared", 32'(ld_stall), 32'd1);
    tick();
    ld_en = 1'b0;
    wait_empty("conflict_drain_empty");

    // Asynchronous reset in the middle of a cycle discards pending stores.
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_st(32'h7000 + 32'(i * 4), 32'h7700 + 32'(i), 2'd2);
      tick();
    end
    st_en = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_req_drop", 32'(mem_req), 32'd0);
    tick();
    rst_n = 1'b1;
    mem_gnt = 1'b1;
    tick();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_req", 32'(mem_req), 32'd0);
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
